// File: rtl/verify_pkg.sv
// Shared codes and state encoding for the instruction compare/decode blocks.
package verify_pkg;

  localparam logic [5:0] COMP_A    = 6'b111101;
  localparam logic [5:0] COMP_B    = 6'b111110;
  localparam logic [5:0] COMP_NONE = 6'b000000;

  localparam logic [2:0] INST_A    = 3'b010;
  localparam logic [2:0] INST_B    = 3'b001;
  localparam logic [2:0] INST_ILL  = 3'b111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    ISSUE  = 2'd2
  } state_e;

endpackage

// File: rtl/verify_comp_map.sv
// Combinational compare-field to {comp, inst} mapping, shared by decode blocks.
module verify_comp_map
  import verify_pkg::*;
(
  input  logic [3:0] field_i,
  output logic [5:0] comp_o,
  output logic [2:0] inst_o
);

  always_comb begin
    comp_o = COMP_NONE;
    inst_o = INST_ILL;
    case (field_i)
      4'b0001: begin
        comp_o = COMP_A;
        inst_o = INST_A;
      end
      4'b0010: begin
        comp_o = COMP_B;
        inst_o = INST_B;
      end
      default: begin
        comp_o = COMP_NONE;
        inst_o = INST_ILL;
      end
    endcase
  end

endmodule

// File: rtl/verify_issue_seq.sv
// Issue sequencer: accepts an instruction word, decodes its compare field and
// presents the result downstream with a stall timeout and statistics counters.
//
//   state  | meaning
//   IDLE   | ready for a new word; decoded outputs hold their last value
//   DECODE | one cycle: register comp/inst/data, or drop an illegal word
//   ISSUE  | out_valid high until out_ready or stall timeout
module verify_issue_seq
  import verify_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int TIMEOUT      = 15,
  parameter int DROP_ILLEGAL = 1,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [5:0]        out_comp,
  output logic [2:0]        out_inst,
  output logic              busy,
  output logic              err_timeout,
  output logic [CNT_W-1:0]  cnt_issued,
  output logic [CNT_W-1:0]  cnt_dropped
);

  // The stall counter holds the number of stalled cycles already seen, so the
  // word is abandoned on the cycle where it would reach TIMEOUT.
  localparam logic [7:0] STALL_LAST = 8'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   word_q;
  logic [DATA_W-1:0]   out_data_q;
  logic [5:0]          out_comp_q;
  logic [2:0]          out_inst_q;
  logic [7:0]          stall_q;
  logic                err_q;
  logic [CNT_W-1:0]    cnt_issued_q;
  logic [CNT_W-1:0]    cnt_dropped_q;

  logic [3:0]          field;
  logic [5:0]          map_comp;
  logic [2:0]          map_inst;
  logic                drop_word;
  logic                stall_hit;

  assign field     = {word_q[31:30], word_q[1:0]};
  assign drop_word = (DROP_ILLEGAL != 0) && (map_inst == INST_ILL);
  assign stall_hit = (stall_q == STALL_LAST);

  verify_comp_map u_comp_map (
    .field_i (field),
    .comp_o  (map_comp),
    .inst_o  (map_inst)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = DECODE;
      DECODE:  state_d = drop_word ? IDLE : ISSUE;
      ISSUE:   if (out_ready || stall_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == ISSUE);
    busy      = (state_q != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_q        <= '0;
      out_data_q    <= '0;
      out_comp_q    <= COMP_NONE;
      out_inst_q    <= INST_ILL;
      stall_q       <= 8'd0;
      err_q         <= 1'b0;
      cnt_issued_q  <= '0;
      cnt_dropped_q <= '0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid) word_q <= in_data;
        end
        DECODE: begin
          out_data_q <= word_q;
          out_comp_q <= map_comp;
          out_inst_q <= map_inst;
          stall_q    <= 8'd0;
          if (drop_word) cnt_dropped_q <= cnt_dropped_q + CNT_W'(1);
        end
        ISSUE: begin
          if (out_ready) begin
            cnt_issued_q <= cnt_issued_q + CNT_W'(1);
          end else begin
            stall_q <= stall_q + 8'd1;
            if (stall_hit) begin
              err_q         <= 1'b1;
              cnt_dropped_q <= cnt_dropped_q + CNT_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign out_data    = out_data_q;
  assign out_comp    = out_comp_q;
  assign out_inst    = out_inst_q;
  assign err_timeout = err_q;
  assign cnt_issued  = cnt_issued_q;
  assign cnt_dropped = cnt_dropped_q;

endmodule

// File: tb/tb_verify_issue_seq.sv
// Directed bench for verify_issue_seq: default instance plus a pass-through
// (DROP_ILLEGAL=0, 2-bit counter) instance for illegal issue and wrap cases.
module tb_verify_issue_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, out_ready;
  logic [31:0] in_data;
  logic        in_ready, out_valid, busy, err_timeout;
  logic [31:0] out_data;
  logic [5:0]  out_comp;
  logic [2:0]  out_inst;
  logic [15:0] cnt_issued, cnt_dropped;

  logic        in_valid_b, out_ready_b;
  logic [31:0] in_data_b;
  logic        in_ready_b, out_valid_b, busy_b, err_timeout_b;
  logic [31:0] out_data_b;
  logic [5:0]  out_comp_b;
  logic [2:0]  out_inst_b;
  logic [1:0]  cnt_issued_b, cnt_dropped_b;

  int checks   = 0;
  int failures = 0;
  int n;

  always #5 clk = ~clk;

  verify_issue_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_comp(out_comp), .out_inst(out_inst),
    .busy(busy), .err_timeout(err_timeout),
    .cnt_issued(cnt_issued), .cnt_dropped(cnt_dropped)
  );

  verify_issue_seq #(.DROP_ILLEGAL(0), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_data(in_data_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_data(out_data_b), .out_comp(out_comp_b), .out_inst(out_inst_b),
    .busy(busy_b), .err_timeout(err_timeout_b),
    .cnt_issued(cnt_issued_b), .cnt_dropped(cnt_dropped_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    in_valid_b = 1'b0; out_ready_b = 1'b0; in_data_b = '0;
    step(); step();
    rst = 1'b0;

    // reset values
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_comp", out_comp, 0);
    chk("rst_out_inst", out_inst, 3'b111);
    chk("rst_cnt_issued", cnt_issued, 0);
    chk("rst_cnt_dropped", cnt_dropped, 0);

    // legal word A with immediate out_ready
    in_data = 32'h0000_0001; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("t1_dec_in_ready", in_ready, 0);
    chk("t1_dec_busy", busy, 1);
    chk("t1_dec_out_valid", out_valid, 0);
    step();
    chk("t1_out_valid", out_valid, 1);
    chk("t1_out_comp", out_comp, 6'b111101);
    chk("t1_out_inst", out_inst, 3'b010);
    chk("t1_out_data", out_data, 32'h0000_0001);
    step();
    chk("t1_done_out_valid", out_valid, 0);
    chk("t1_cnt_issued", cnt_issued, 1);
    chk("t1_in_ready", in_ready, 1);

    // illegal word dropped
    in_data = 32'h4000_0002; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("t2_dec_in_ready", in_ready, 0);
    chk("t2_dec_out_valid", out_valid, 0);
    step();
    chk("t2_in_ready", in_ready, 1);
    chk("t2_out_valid", out_valid, 0);
    chk("t2_cnt_dropped", cnt_dropped, 1);
    chk("t2_cnt_issued", cnt_issued, 1);
    chk("t2_out_inst", out_inst, 3'b111);
    step();
    chk("t2_out_valid_later", out_valid, 0);

    // stall timeout
    out_ready = 1'b0; in_data = 32'h0000_0002; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    n = 0;
    while (out_valid && n < 40) begin
      n++;
      chk("t3_err_during_stall", err_timeout, 0);
      step();
    end
    chk("t3_valid_cycles", n, 15);
    chk("t3_err_pulse", err_timeout, 1);
    chk("t3_cnt_dropped", cnt_dropped, 2);
    chk("t3_cnt_issued", cnt_issued, 1);
    chk("t3_in_ready", in_ready, 1);
    chk("t3_out_comp", out_comp, 6'b111110);
    chk("t3_out_inst", out_inst, 3'b001);
    step();
    chk("t3_err_cleared", err_timeout, 0);

    // handshake on the 15th stalled cycle wins; in_data changes are ignored
    in_data = 32'h3C00_0002; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    in_data = 32'hFFFF_FFFF;
    step();
    repeat (14) step();
    chk("t4_valid_c15", out_valid, 1);
    in_data = 32'h0000_0001;
    out_ready = 1'b1;
    step();
    chk("t4_out_valid", out_valid, 0);
    chk("t4_err", err_timeout, 0);
    chk("t4_cnt_issued", cnt_issued, 2);
    chk("t4_cnt_dropped", cnt_dropped, 2);
    chk("t4_out_data_held", out_data, 32'h3C00_0002);
    chk("t4_out_comp", out_comp, 6'b111110);

    // reset while in ISSUE dominates a pending handshake
    out_ready = 1'b0; in_data = 32'h0000_0001; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    chk("t5_pre_out_valid", out_valid, 1);
    rst = 1'b1; out_ready = 1'b1;
    step();
    rst = 1'b0; out_ready = 1'b0;
    chk("t5_out_valid", out_valid, 0);
    chk("t5_in_ready", in_ready, 1);
    chk("t5_cnt_issued", cnt_issued, 0);
    chk("t5_cnt_dropped", cnt_dropped, 0);
    chk("t5_out_inst", out_inst, 3'b111);
    chk("t5_out_data", out_data, 0);

    // pass-through instance: illegal word issued, then counter wrap
    out_ready_b = 1'b1;
    in_data_b = 32'h4000_0002; in_valid_b = 1'b1;
    step();
    in_valid_b = 1'b0;
    step();
    chk("b_ill_out_valid", out_valid_b, 1);
    chk("b_ill_out_comp", out_comp_b, 6'b000000);
    chk("b_ill_out_inst", out_inst_b, 3'b111);
    step();
    chk("b_cnt_issued_1", cnt_issued_b, 1);
    chk("b_cnt_dropped", cnt_dropped_b, 0);
    for (int i = 0; i < 2; i++) begin
      in_data_b = 32'h0000_0001; in_valid_b = 1'b1;
      step();
      in_valid_b = 1'b0;
      step(); step();
    end
    chk("b_cnt_issued_3", cnt_issued_b, 3);
    in_data_b = 32'h0000_0001; in_valid_b = 1'b1;
    step();
    in_valid_b = 1'b0;
    step(); step();
    chk("b_cnt_wrap", cnt_issued_b, 0);
    chk("b_err", err_timeout_b, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
